// File: rtl/seg7_x16_pkg.sv
// Shared display definitions for the 8-digit seven-segment scanner:
// the hex glyph table, blank constants, display mode encoding and a
// helper that turns a digit address into an active-low anode select.
package seg7_x16_pkg;

    // All segments off (active-low), dp included.
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // No anode driven (active-low), every digit dark.
    localparam logic [7:0] SEL_NONE = 8'hFF;

    // Active-low glyphs, bit order {dp,g,f,e,d,c,b,a}, dp off.
    localparam logic [7:0] HEX_GLYPH [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0,
        8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83,
        8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    // Text mode shows 8 hex nibbles; graphics mode drives raw segment bytes.
    typedef enum logic {
        MODE_TEXT     = 1'b0,
        MODE_GRAPHICS = 1'b1
    } display_mode_t;

    // Active-low one-hot anode select for a digit address (digit 0 rightmost).
    function automatic logic [7:0] digitSelect(input logic [2:0] addr);
        return ~(8'b0000_0001 << addr);
    endfunction

endpackage

// File: rtl/seg7_x16_hex_to_seg7.sv
// Combinational nibble-to-glyph decoder for a single hex digit.
module hex_to_seg7
    import seg7_x16_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [7:0] o_glyph
);

    // Straight table lookup; the table is shared through the package.
    always_comb begin
        o_glyph = HEX_GLYPH[i_nibble];
    end

endmodule

// File: rtl/seg7_x16.sv
// Eight-digit multiplexed seven-segment driver. A free-running divider
// produces a scan tick that steps the digit address; the payload and
// mode are re-captured every clock, and the select/segment pair is
// registered together so a lit anode never shows another digit's pattern.
module seg7_x16
    import seg7_x16_pkg::*;
#(
    parameter int DIV_BIT = 14
)
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        display_mode,
    input  logic [63:0] i_data,
    output logic [7:0]  o_seg,
    output logic [7:0]  o_sel
);

    logic [DIV_BIT:0] r_cnt;
    logic [2:0]       r_addr;
    logic [63:0]      r_hold;
    display_mode_t    r_mode;
    logic [7:0]       r_seg;
    logic [7:0]       r_sel;

    logic             w_tick;
    logic [3:0]       w_nibble;
    logic [7:0]       w_byte;
    logic [7:0]       w_glyph;
    logic [7:0]       w_segNext;

    // Free-running scan divider; wraps naturally at its full width.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + {{DIV_BIT{1'b0}}, 1'b1};
        end
    end

    // Scan strobe: one cycle long, once every 2^DIV_BIT clocks.
    always_comb begin
        w_tick = &r_cnt[DIV_BIT-1:0];
    end

    // Digit address steps on each tick and wraps 7 -> 0.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_addr <= '0;
        end else if (w_tick) begin
            r_addr <= r_addr + 3'd1;
        end
    end

    // Payload and mode are sampled every clock so the decoder only sees registered values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_hold <= '0;
            r_mode <= MODE_TEXT;
        end else begin
            r_hold <= i_data;
            r_mode <= display_mode_t'(display_mode);
        end
    end

    // Pick the nibble and the raw byte belonging to the current digit.
    always_comb begin
        w_nibble = r_hold[{r_addr, 2'b00} +: 4];
        w_byte   = r_hold[{r_addr, 3'b000} +: 8];
    end

    hex_to_seg7 u_hexToSeg7 (
        .i_nibble (w_nibble),
        .o_glyph  (w_glyph)
    );

    // Graphics mode passes the byte through untouched, dp bit included.
    always_comb begin
        w_segNext = w_glyph;
        if (r_mode == MODE_GRAPHICS) begin
            w_segNext = w_byte;
        end
    end

    // Select and segments load on the same edge so they always describe the same digit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sel <= SEL_NONE;
            r_seg <= SEG_BLANK;
        end else begin
            r_sel <= digitSelect(r_addr);
            r_seg <= w_segNext;
        end
    end

    assign o_sel = r_sel;
    assign o_seg = r_seg;

endmodule

// File: tb/tb_seg7_x16.sv
// Self-checking bench for seg7_x16 with a short scan divider. Expected
// select/segment pairs are queued when a payload is applied and popped
// as each digit's dwell window comes around.
module tb_seg7_x16;

    localparam int DIV_BIT = 2;
    localparam int DWELL   = 1 << DIV_BIT;

    typedef struct packed {
        logic [7:0] sel;
        logic [7:0] seg;
    } pair_t;

    logic        clk          = 1'b0;
    logic        rstn         = 1'b1;
    logic        display_mode = 1'b0;
    logic [63:0] i_data       = '0;
    logic [7:0]  o_seg;
    logic [7:0]  o_sel;

    int checkCount = 0;
    int errorCount = 0;
    int edgeCount  = 0;
    int slot       = 0;

    pair_t expQ[$];

    logic [7:0] glyphTable [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    seg7_x16 #(
        .DIV_BIT (DIV_BIT)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .display_mode (display_mode),
        .i_data       (i_data),
        .o_seg        (o_seg),
        .o_sel        (o_sel)
    );

    // 100 MHz-style clock, period 10.
    always #5 clk = ~clk;

    // Guard against the run ever stalling.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
        edgeCount++;
    endtask

    task automatic waitUntilEdge(input int target);
        while (edgeCount < target) stepClock();
    endtask

    function automatic pair_t expectedPair(input logic [63:0] d, input logic m, input int k);
        pair_t p;
        p.sel = ~(8'b0000_0001 << k);
        p.seg = m ? d[8*k +: 8] : glyphTable[d[4*k +: 4]];
        return p;
    endfunction

    // Drive a payload/mode and queue the expected pair for digits firstDigit..7.
    task automatic applyStimulus(input logic [63:0] d, input logic m, input int firstDigit);
        i_data       = d;
        display_mode = m;
        for (int k = firstDigit; k < 8; k++) expQ.push_back(expectedPair(d, m, k));
    endtask

    // Sample n consecutive digits near the end of each dwell and compare with the queue.
    task automatic drainDigits(input string tag, input int n);
        pair_t p;
        for (int i = 0; i < n; i++) begin
            waitUntilEdge(DWELL*slot + DWELL - 1);
            if (expQ.size() == 0) begin
                checkOutput($sformatf("%s queue d%0d", tag, slot % 8), 8'h00, 8'h01);
            end else begin
                p = expQ.pop_front();
                checkOutput($sformatf("%s d%0d sel", tag, slot % 8), o_sel, p.sel);
                checkOutput($sformatf("%s d%0d seg", tag, slot % 8), o_seg, p.seg);
            end
            slot++;
        end
    endtask

    initial begin
        // Power-on reset with an asynchronous falling edge.
        #1 rstn = 1'b0;
        #2;
        checkOutput("reset async sel", o_sel, 8'hFF);
        checkOutput("reset async seg", o_seg, 8'hFF);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset held sel", o_sel, 8'hFF);
        checkOutput("reset held seg", o_seg, 8'hFF);

        applyStimulus(64'h0000_0000_7654_3210, 1'b0, 0);
        @(negedge clk);
        rstn      = 1'b1;
        edgeCount = 0;
        slot      = 0;
        stepClock();
        checkOutput("release sel", o_sel, 8'hFE);
        checkOutput("release seg", o_seg, 8'hC0);

        drainDigits("textA", 8);

        // Next scan starts at digit 0 again, so the address wrap is covered here.
        applyStimulus(64'hDEAD_BEEF_FEDC_BA98, 1'b0, 0);
        drainDigits("textB", 8);

        applyStimulus(64'hFF_FF_FF_FE_FE_FE_FE_FE, 1'b1, 0);
        drainDigits("gfx", 8);

        // Mode flip in the middle of digit 3.
        i_data       = 64'h0000_00AA_0000_3000;
        display_mode = 1'b0;
        for (int k = 0; k < 4; k++) expQ.push_back(expectedPair(i_data, 1'b0, k));
        drainDigits("modeText", 3);
        begin
            pair_t p;
            waitUntilEdge(DWELL*slot + 1);
            p = expQ.pop_front();
            checkOutput("mode d3 text sel", o_sel, p.sel);
            checkOutput("mode d3 text seg", o_seg, p.seg);
            display_mode = 1'b1;
            waitUntilEdge(DWELL*slot + 3);
            checkOutput("mode d3 gfx sel", o_sel, 8'hF7);
            checkOutput("mode d3 gfx seg", o_seg, 8'h00);
            slot++;
        end
        for (int k = 4; k < 8; k++) expQ.push_back(expectedPair(i_data, 1'b1, k));
        drainDigits("modeGfx", 4);

        // Reset while digit 5 is on screen.
        applyStimulus(64'h0000_0000_0123_4567, 1'b0, 0);
        drainDigits("preReset", 5);
        waitUntilEdge(DWELL*slot + 2);
        rstn = 1'b0;
        #1;
        checkOutput("midReset async sel", o_sel, 8'hFF);
        checkOutput("midReset async seg", o_seg, 8'hFF);
        expQ.delete();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("midReset held sel", o_sel, 8'hFF);
        checkOutput("midReset held seg", o_seg, 8'hFF);
        @(negedge clk);
        rstn      = 1'b1;
        edgeCount = 0;
        slot      = 0;
        stepClock();
        checkOutput("restart sel", o_sel, 8'hFE);
        checkOutput("restart seg", o_seg, 8'hC0);
        applyStimulus(64'h0000_0000_0123_4567, 1'b0, 0);
        drainDigits("postReset", 8);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
